// File: rtl/fpga_banked_ram.sv
// Word-interleaved multi-bank block RAM with req/gnt/rvalid handshake,
// optional output register and a post-reset zero-fill sequencer.
//
// state    | meaning
// ST_INIT  | zero-filling one row of every bank per cycle, no grants
// ST_READY | granting one request per cycle, responses in order
module fpga_banked_ram #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int BE_WIDTH   = DATA_WIDTH / 8,
  parameter int NUM_BANKS  = 2,
  parameter int OUT_REG    = 1,
  parameter int INIT_ZERO  = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_i,
  output logic                  gnt_o,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [BE_WIDTH-1:0]   be_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  rvalid_o,
  output logic                  init_done_o
);

  localparam int BANK_BITS = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 0;
  localparam int BSW       = (BANK_BITS > 0) ? BANK_BITS : 1;
  localparam int ROW_BITS  = ADDR_WIDTH - BANK_BITS;
  localparam int ROWS      = 2 ** ROW_BITS;

  localparam logic [0:0] ST_INIT  = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  logic [0:0]            state;
  logic [ROW_BITS-1:0]   cnt;
  logic                  ready;
  logic                  acc;
  logic [BSW-1:0]        bank_sel;
  logic [ROW_BITS-1:0]   row_sel;
  logic [ROW_BITS-1:0]   mem_row;
  logic [BE_WIDTH-1:0]   mem_be;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [NUM_BANKS-1:0][DATA_WIDTH-1:0] rd_bus;
  logic [DATA_WIDTH-1:0] mux_data;
  logic                  v1;
  logic [BSW-1:0]        bank_q;

  // Outputs are masked by rst_i so nothing is granted while reset is held.
  assign ready       = (state == ST_READY);
  assign gnt_o       = ready & ~rst_i;
  assign init_done_o = ready & ~rst_i;
  assign acc         = req_i & gnt_o;
  assign row_sel     = addr_i[ADDR_WIDTH-1:BANK_BITS];

  if (NUM_BANKS > 1) begin : g_sel
    assign bank_sel = addr_i[BSW-1:0];
    assign mux_data = rd_bus[bank_q];
  end else begin : g_nosel
    assign bank_sel = '0;
    assign mux_data = rd_bus[0];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= (INIT_ZERO != 0) ? ST_INIT : ST_READY;
      cnt   <= '0;
    end else if (state == ST_INIT) begin
      cnt <= cnt + 1'b1;
      if (&cnt) state <= ST_READY;
    end
  end

  always_comb begin
    mem_row   = row_sel;
    mem_be    = be_i;
    mem_wdata = wdata_i;
    if (!ready) begin
      mem_row   = cnt;
      mem_be    = '1;
      mem_wdata = '0;
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [DATA_WIDTH-1:0] mem [ROWS];
    logic [DATA_WIDTH-1:0] rd_q;
    logic                  hit;
    logic                  wr_en;

    assign hit   = (bank_sel == BSW'(b));
    assign wr_en = ready ? (acc & hit & we_i) : ~rst_i;

    always_ff @(posedge clk_i) begin
      for (int k = 0; k < BE_WIDTH; k++) begin
        if (wr_en && mem_be[k]) mem[mem_row][k*8 +: 8] <= mem_wdata[k*8 +: 8];
      end
    end

    // Read-first: the read sees the row before this edge's write lands.
    always_ff @(posedge clk_i) begin
      if (rst_i) rd_q <= '0;
      else if (acc && hit) rd_q <= mem[mem_row];
    end

    assign rd_bus[b] = rd_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      v1     <= 1'b0;
      bank_q <= '0;
    end else begin
      v1 <= acc;
      if (acc) bank_q <= bank_sel;
    end
  end

  if (OUT_REG != 0) begin : g_oreg
    logic                  v2;
    logic [DATA_WIDTH-1:0] rdata_q;
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        v2      <= 1'b0;
        rdata_q <= '0;
      end else begin
        v2 <= v1;
        if (v1) rdata_q <= mux_data;
      end
    end
    assign rvalid_o = v2;
    assign rdata_o  = rdata_q;
  end else begin : g_noreg
    assign rvalid_o = v1;
    assign rdata_o  = mux_data;
  end

endmodule

// File: tb/tb_fpga_banked_ram.sv
// Scoreboard bench: a default instance (2 banks, output register, zero-fill)
// and an alternate one (1 bank, no output register, no zero-fill).
module tb_fpga_banked_ram;

  typedef struct {
    int          cyc;
    bit          chk;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int ncyc = 0;
  always @(posedge clk) ncyc <= ncyc + 1;

  logic        rst0, req0, we0, gnt0, rv0, done0;
  logic [11:0] addr0;
  logic [3:0]  be0;
  logic [31:0] wd0, rd0;
  logic        rst1, req1, we1, gnt1, rv1, done1;
  logic [11:0] addr1;
  logic [3:0]  be1;
  logic [31:0] wd1, rd1;

  fpga_banked_ram u_dut (
    .clk_i(clk), .rst_i(rst0), .req_i(req0), .gnt_o(gnt0), .we_i(we0),
    .addr_i(addr0), .be_i(be0), .wdata_i(wd0), .rdata_o(rd0),
    .rvalid_o(rv0), .init_done_o(done0)
  );

  fpga_banked_ram #(.NUM_BANKS(1), .OUT_REG(0), .INIT_ZERO(0)) u_alt (
    .clk_i(clk), .rst_i(rst1), .req_i(req1), .gnt_o(gnt1), .we_i(we1),
    .addr_i(addr1), .be_i(be1), .wdata_i(wd1), .rdata_o(rd1),
    .rvalid_o(rv1), .init_done_o(done1)
  );

  int n_chk = 0;
  int n_err = 0;
  exp_t q0[$];
  exp_t q1[$];
  logic [31:0] model0 [int];
  logic [31:0] model1 [int];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int k = 0; k < 4; k++) if (be[k]) r[k*8 +: 8] = wd[k*8 +: 8];
    return r;
  endfunction

  // Drives one request on port p at a negedge; acceptance is the next posedge.
  task automatic issue(input int p, input logic we, input logic [11:0] a,
                       input logic [3:0] be, input logic [31:0] wd, input bit push);
    exp_t e;
    logic [31:0] old;
    @(negedge clk);
    if (p == 0) begin
      req0 = 1'b1; we0 = we; addr0 = a; be0 = be; wd0 = wd; req1 = 1'b0;
      check("gnt0", gnt0, 1);
      old   = model0.exists(int'(a)) ? model0[int'(a)] : 32'h0;
      e.chk = 1'b1;
      if (we) model0[int'(a)] = merge(old, wd, be);
      e.cyc  = ncyc + 2;
      e.data = old;
      if (push) q0.push_back(e);
    end else begin
      req1 = 1'b1; we1 = we; addr1 = a; be1 = be; wd1 = wd; req0 = 1'b0;
      check("gnt1", gnt1, 1);
      e.chk = model1.exists(int'(a));
      old   = e.chk ? model1[int'(a)] : 32'h0;
      if (we) model1[int'(a)] = merge(old, wd, be);
      e.cyc  = ncyc + 1;
      e.data = old;
      if (push) q1.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      req0 = 1'b0;
      req1 = 1'b0;
    end
  endtask

  // Called right after rst is released at a negedge; counts cycles with gnt low.
  task automatic init_count(input int p, input int exp_len);
    int n;
    n = 0;
    #1;
    while (((p == 0) ? gnt0 : gnt1) == 1'b0 && n < 5000) begin
      n++;
      @(negedge clk);
      #1;
    end
    check(p == 0 ? "init_len0" : "init_len1", 64'(n), 64'(exp_len));
    check(p == 0 ? "init_done0" : "init_done1", (p == 0) ? done0 : done1, 1);
  endtask

  exp_t e0, e1;
  always @(negedge clk) begin
    if (rv0) begin
      if (q0.size() == 0) check("rvalid0_unexpected", 1, 0);
      else begin
        e0 = q0.pop_front();
        check("lat0", 64'(ncyc), 64'(e0.cyc));
        check("rdata0", rd0, e0.data);
      end
    end
    if (rv1) begin
      if (q1.size() == 0) check("rvalid1_unexpected", 1, 0);
      else begin
        e1 = q1.pop_front();
        check("lat1", 64'(ncyc), 64'(e1.cyc));
        if (e1.chk) check("rdata1", rd1, e1.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst0 = 1'b1; req0 = 1'b0; we0 = 1'b0; addr0 = '0; be0 = '0; wd0 = '0;
    rst1 = 1'b1; req1 = 1'b0; we1 = 1'b0; addr1 = '0; be1 = '0; wd1 = '0;
    repeat (3) @(negedge clk);
    check("reset_gnt0", gnt0, 0);
    check("reset_rvalid0", rv0, 0);
    check("reset_rdata0", rd0, 0);
    check("reset_done0", done0, 0);
    check("reset_gnt1", gnt1, 0);

    // Alternate instance: granted immediately, 1-cycle latency.
    rst1 = 1'b0;
    init_count(1, 0);
    issue(1, 1'b1, 12'h7FF, 4'hF, 32'h12345678, 1'b1);
    issue(1, 1'b0, 12'h7FF, 4'h0, 32'h0, 1'b1);
    issue(1, 1'b1, 12'h002, 4'hF, 32'h0000000A, 1'b1);
    issue(1, 1'b1, 12'h003, 4'hF, 32'h0000000B, 1'b1);
    issue(1, 1'b0, 12'h002, 4'h0, 32'h0, 1'b1);
    issue(1, 1'b0, 12'h003, 4'h0, 32'h0, 1'b1);
    issue(1, 1'b1, 12'h003, 4'b1000, 32'hFF000000, 1'b1);
    issue(1, 1'b0, 12'h003, 4'h0, 32'h0, 1'b1);
    idle(3);

    // Default instance: zero-fill then the main traffic.
    rst0 = 1'b0;
    init_count(0, 2048);
    issue(0, 1'b0, 12'h000, 4'h0, 32'h0, 1'b1);
    issue(0, 1'b0, 12'hFFF, 4'h0, 32'h0, 1'b1);
    issue(0, 1'b1, 12'h005, 4'hF, 32'hDEADBEEF, 1'b1);
    issue(0, 1'b1, 12'h005, 4'b0101, 32'h11223344, 1'b1);
    issue(0, 1'b0, 12'h005, 4'h0, 32'h0, 1'b1);
    issue(0, 1'b1, 12'h002, 4'hF, 32'h0000000A, 1'b1);
    issue(0, 1'b1, 12'h003, 4'hF, 32'h0000000B, 1'b1);
    idle(1);
    issue(0, 1'b0, 12'h002, 4'h0, 32'h0, 1'b1);
    issue(0, 1'b0, 12'h003, 4'h0, 32'h0, 1'b1);
    issue(0, 1'b1, 12'h010, 4'hF, 32'h55AA55AA, 1'b1);
    issue(0, 1'b0, 12'h010, 4'h0, 32'h0, 1'b1);
    issue(0, 1'b1, 12'h011, 4'h0, 32'hFFFFFFFF, 1'b1);
    issue(0, 1'b0, 12'h011, 4'h0, 32'h0, 1'b1);
    check("model_5", model0[5], 32'hDE22BE44);
    issue(0, 1'b1, 12'h020, 4'hF, 32'hCAFEF00D, 1'b1);
    idle(3);

    // Reset right after a granted read: its response must never appear.
    issue(0, 1'b0, 12'h020, 4'h0, 32'h0, 1'b0);
    @(negedge clk);
    req0 = 1'b0;
    rst0 = 1'b1;
    @(negedge clk);
    check("rst_gnt0", gnt0, 0);
    check("rst_rvalid0", rv0, 0);
    check("rst_done0", done0, 0);
    model0.delete();
    @(negedge clk);
    rst0 = 1'b0;
    init_count(0, 2048);
    issue(0, 1'b0, 12'h020, 4'h0, 32'h0, 1'b1);
    issue(0, 1'b0, 12'h005, 4'h0, 32'h0, 1'b1);
    idle(5);

    check("q0_drained", 64'(q0.size()), 0);
    check("q1_drained", 64'(q1.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
